aes_fifo_block_sched: RTL

- Sequences the AES datapath between the OCL-fed input word FIFO and the readback output word FIFO.
- Pops four 32-bit words from the input FIFO and packs them into one 128-bit block.
- Starts the AES core with that block, waits for completion, then pushes the four result words into the output FIFO.
- Sits between the local FIFOs and the AES core in the CL, on clk_main_a0.

---
 rtl/aes_fifo_block_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aes_fifo_block_sched.sv
// aes_fifo_block_sched: sequences one AES block at a time.
// It pops four words from the input FIFO, starts the AES core, waits for the
// result, and then pushes the four result words into the output FIFO.
// Optional: define AES_SCHED_TIMEOUT_EN to enable a watchdog on WAIT.
// When it fires, the block sets sts_timeout and parks in ERR until ctl_clear.
module aes_fifo_block_sched #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk_main_a0,
  input  logic             rst_main_n,
  input  logic             ctl_enable,
  input  logic             ctl_clear,
  input  logic             in_empty,
  output logic             in_rd_en,
  input  logic [31:0]      in_rdata,
  output logic             aes_start,
  output logic [127:0]     aes_din,
  input  logic             aes_done,
  input  logic [127:0]     aes_dout,
  input  logic             out_full,
  output logic             out_wr_en,
  output logic [31:0]      out_wdata,
  output logic             sts_busy,
  output logic [2:0]       sts_state,
  output logic [CNT_W-1:0] sts_blk_cnt,
  output logic             sts_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATHER = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  state_t         state;
  logic [2:0]     issued;   // pops issued in the current block
  logic [1:0]     cap_cnt;  // words captured so far; also the pack slot
  logic           rd_pend;  // in_rdata carries a popped word this cycle
  logic [2:0]     written;  // result words pushed so far
  logic [127:0]   result;

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag;
  assign sts_timeout = tmo_flag;
`else
  assign sts_timeout = 1'b0;
`endif

  // FIFO strobes are decoded combinationally so that they respond to
  // empty/full in the same cycle and never pop empty or push full.
  assign in_rd_en  = (state == ST_GATHER) && !in_empty && (issued < 3'd4);
  assign out_wr_en = (state == ST_DRAIN) && !out_full && (written < 3'd4);
  // The MSB word goes first: slot k occupies bits [127-32k -: 32].
  assign out_wdata = result[{~written[1:0], 5'b0} +: 32];
  assign aes_start = (state == ST_START);
  assign sts_busy  = (state != ST_IDLE);
  assign sts_state = state;

  // Block sequencer. ctl_clear overrides everything else that happens in the same cycle.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state       <= ST_IDLE;
      issued      <= '0;
      cap_cnt     <= '0;
      rd_pend     <= 1'b0;
      written     <= '0;
      result      <= '0;
      aes_din     <= '0;
      sts_blk_cnt <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      tmo_cnt     <= '0;
      tmo_flag    <= 1'b0;
`endif
    end else if (ctl_clear) begin
      // A pop issued in this cycle still leaves the FIFO. Clearing rd_pend
      // drops its data.
      state       <= ST_IDLE;
      issued      <= '0;
      cap_cnt     <= '0;
      rd_pend     <= 1'b0;
      written     <= '0;
      sts_blk_cnt <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      tmo_cnt     <= '0;
      tmo_flag    <= 1'b0;
`endif
    end else begin
      rd_pend <= in_rd_en;
      case (state)
        ST_IDLE: if (ctl_enable) state <= ST_GATHER;
        ST_GATHER: begin
          if (in_rd_en) issued <= issued + 3'd1;
          if (rd_pend) begin
            aes_din[{~cap_cnt, 5'b0} +: 32] <= in_rdata;
            cap_cnt <= cap_cnt + 2'd1;
            if (cap_cnt == 2'd3) begin
              issued <= '0;
              state  <= ST_START;
            end
          end
        end
        ST_START: begin
          state <= ST_WAIT;
`ifdef AES_SCHED_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (aes_done) begin
            result  <= aes_dout;
            written <= '0;
            state   <= ST_DRAIN;
          end
`ifdef AES_SCHED_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_flag <= 1'b1;
            state    <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        ST_DRAIN: begin
          if (out_wr_en) begin
            written <= written + 3'd1;
            if (written == 3'd3) begin
              written     <= '0;
              sts_blk_cnt <= sts_blk_cnt + CNT_W'(1);
              state       <= ctl_enable ? ST_GATHER : ST_IDLE;
            end
          end
        end
        ST_ERR: state <= ST_ERR;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
